reg_bank: RTL and testbench

Parametrised general-purpose register bank for the 4-bit CPU datapath. It is the successor to the single load/clear register. It holds NUM_REGS registers of WIDTH bits, each with write-load, in-place increment with carry detection, two read ports and a free-running cycle counter. It sits between the instruction decoder (which drives the write, increment and select lines) and the ALU (which consumes the read ports and the carry).

---
 rtl/reg_bank_if.sv | 30 +++
 rtl/reg_bank.sv | 70 +++++++
 tb/tb_reg_bank.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// Decoder/ALU-facing bus of the register bank: write, increment, read-select lines and status outputs.
interface reg_bank_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 sclr;
    logic                 wr_en;
    logic [SEL_W-1:0]     wr_sel;
    logic [WIDTH-1:0]     wr_data;
    logic                 inc_en;
    logic [SEL_W-1:0]     inc_sel;
    logic [SEL_W-1:0]     rd_sel_a;
    logic [WIDTH-1:0]     rd_data_a;
    logic [SEL_W-1:0]     rd_sel_b;
    logic [WIDTH-1:0]     rd_data_b;
    logic                 carry_out;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic                 cycle_wrap;

    modport master (
        output sclr, wr_en, wr_sel, wr_data, inc_en, inc_sel, rd_sel_a, rd_sel_b,
        input  rd_data_a, rd_data_b, carry_out, cycle_count, cycle_wrap
    );

    modport slave (
        input  sclr, wr_en, wr_sel, wr_data, inc_en, inc_sel, rd_sel_a, rd_sel_b,
        output rd_data_a, rd_data_b, carry_out, cycle_count, cycle_wrap
    );
endinterface

// File: rtl/reg_bank.sv
// Register bank with write-load, increment with carry pulse, two combinational read ports
// and a free-running cycle counter with wrap pulse.
module reg_bank #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic      clk,
    input  logic      clr_n,
    reg_bank_if.slave bus
);
    logic [WIDTH-1:0]     regs_q [NUM_REGS];
    logic [WIDTH-1:0]     regs_d [NUM_REGS];
    logic                 carry_d;
    logic                 carry_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 wrap_q;
    logic [WIDTH-1:0]     rd_a;
    logic [WIDTH-1:0]     rd_b;

    // Next register state; selects matching no index (out of range) have no effect.
    always_comb begin
        carry_d = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_d[i] = regs_q[i];
            if (bus.wr_en && (bus.wr_sel == SEL_W'(i))) begin
                regs_d[i] = bus.wr_data;
            end else if (bus.inc_en && (bus.inc_sel == SEL_W'(i))) begin
                regs_d[i] = regs_q[i] + WIDTH'(1);
                carry_d   = &regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.sclr) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
            carry_q <= carry_d;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            wrap_q  <= &cnt_q;
        end
    end

    // Read muxes; an unmatched select reads as zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (bus.rd_sel_a == SEL_W'(i)) rd_a = regs_q[i];
            if (bus.rd_sel_b == SEL_W'(i)) rd_b = regs_q[i];
        end
    end

    assign bus.rd_data_a   = rd_a;
    assign bus.rd_data_b   = rd_b;
    assign bus.carry_out   = carry_q;
    assign bus.cycle_count = cnt_q;
    assign bus.cycle_wrap  = wrap_q;
endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: one 4-register instance with a 4-bit counter,
// one 3-register instance for out-of-range selects.
module tb_reg_bank;
    logic clk;
    logic clr_n;
    int   checks;
    int   fails;

    reg_bank_if #(.WIDTH(4), .SEL_W(2), .CNT_WIDTH(4)) ia ();
    reg_bank_if #(.WIDTH(4), .SEL_W(2), .CNT_WIDTH(8)) ib ();

    reg_bank #(.WIDTH(4), .NUM_REGS(4), .SEL_W(2), .CNT_WIDTH(4)) dut_a (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (ia)
    );

    reg_bank #(.WIDTH(4), .NUM_REGS(3), .SEL_W(2), .CNT_WIDTH(8)) dut_b (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        clr_n  = 1'b0;
        ia.sclr = 1'b0; ia.wr_en = 1'b1; ia.wr_sel = 2'd1; ia.wr_data = 4'hF;
        ia.inc_en = 1'b1; ia.inc_sel = 2'd0; ia.rd_sel_a = 2'd1; ia.rd_sel_b = 2'd0;
        ib.sclr = 1'b0; ib.wr_en = 1'b0; ib.wr_sel = 2'd0; ib.wr_data = 4'h0;
        ib.inc_en = 1'b0; ib.inc_sel = 2'd0; ib.rd_sel_a = 2'd0; ib.rd_sel_b = 2'd0;

        // Reset held with strobes active
        tick(); tick(); tick();
        chk("rst_rd_a",  32'(ia.rd_data_a),   32'h0);
        chk("rst_rd_b",  32'(ia.rd_data_b),   32'h0);
        chk("rst_carry", 32'(ia.carry_out),   32'h0);
        chk("rst_cnt",   32'(ia.cycle_count), 32'h0);
        chk("rst_wrap",  32'(ia.cycle_wrap),  32'h0);

        ia.wr_en = 1'b0; ia.inc_en = 1'b0;
        clr_n = 1'b1;
        repeat (5) tick();
        chk("cnt_after_5", 32'(ia.cycle_count), 32'h5);

        // Write/read with no write-through
        ia.wr_en = 1'b1; ia.wr_sel = 2'd1; ia.wr_data = 4'hA;
        ia.rd_sel_a = 2'd1; ia.rd_sel_b = 2'd2;
        #1;
        chk("wr1_same_cycle", 32'(ia.rd_data_a), 32'h0);
        tick();
        chk("wr1_rd_a", 32'(ia.rd_data_a), 32'hA);
        chk("wr1_rd_b", 32'(ia.rd_data_b), 32'h0);
        ia.wr_sel = 2'd2; ia.wr_data = 4'h5;
        #1;
        chk("wr2_same_cycle", 32'(ia.rd_data_b), 32'h0);
        tick();
        chk("wr2_rd_b", 32'(ia.rd_data_b), 32'h5);
        chk("wr2_rd_a", 32'(ia.rd_data_a), 32'hA);
        ia.wr_en = 1'b0;
        ia.rd_sel_b = 2'd1;
        #1;
        chk("both_ports_same", 32'(ia.rd_data_b), 32'hA);

        // Increment E -> F -> 0 -> 1 with one carry pulse
        ia.wr_en = 1'b1; ia.wr_sel = 2'd0; ia.wr_data = 4'hE; ia.rd_sel_a = 2'd0;
        tick();
        ia.wr_en = 1'b0; ia.inc_en = 1'b1; ia.inc_sel = 2'd0;
        chk("inc_pre", 32'(ia.rd_data_a), 32'hE);
        tick();
        chk("inc1_val",   32'(ia.rd_data_a), 32'hF);
        chk("inc1_carry", 32'(ia.carry_out), 32'h0);
        tick();
        chk("inc2_val",   32'(ia.rd_data_a), 32'h0);
        chk("inc2_carry", 32'(ia.carry_out), 32'h1);
        tick();
        chk("inc3_val",   32'(ia.rd_data_a), 32'h1);
        chk("inc3_carry", 32'(ia.carry_out), 32'h0);
        ia.inc_en = 1'b0;

        // Collision on reg3 (write wins, no carry)
        ia.wr_en = 1'b1; ia.wr_sel = 2'd3; ia.wr_data = 4'hF; ia.rd_sel_a = 2'd3;
        tick();
        ia.wr_data = 4'h7; ia.inc_en = 1'b1; ia.inc_sel = 2'd3;
        tick();
        chk("coll_same_val",   32'(ia.rd_data_a), 32'h7);
        chk("coll_same_carry", 32'(ia.carry_out), 32'h0);

        // Write reg3 and increment reg2 (F) together: both apply
        ia.inc_en = 1'b0; ia.wr_sel = 2'd2; ia.wr_data = 4'hF;
        tick();
        ia.wr_sel = 2'd3; ia.wr_data = 4'h4; ia.inc_en = 1'b1; ia.inc_sel = 2'd2;
        ia.rd_sel_b = 2'd2;
        tick();
        chk("coll_diff_wr",    32'(ia.rd_data_a), 32'h4);
        chk("coll_diff_inc",   32'(ia.rd_data_b), 32'h0);
        chk("coll_diff_carry", 32'(ia.carry_out), 32'h1);
        ia.wr_en = 1'b0; ia.inc_en = 1'b0;

        // Out-of-range selects on the 3-register instance
        ib.wr_en = 1'b1; ib.wr_sel = 2'd0; ib.wr_data = 4'h1; tick();
        ib.wr_sel = 2'd1; ib.wr_data = 4'h2; tick();
        ib.wr_sel = 2'd2; ib.wr_data = 4'h3; tick();
        ib.wr_sel = 2'd3; ib.wr_data = 4'h9; ib.inc_en = 1'b1; ib.inc_sel = 2'd3;
        ib.rd_sel_a = 2'd3; ib.rd_sel_b = 2'd0;
        tick();
        ib.wr_en = 1'b0; ib.inc_en = 1'b0;
        chk("oor_rd3",   32'(ib.rd_data_a), 32'h0);
        chk("oor_reg0",  32'(ib.rd_data_b), 32'h1);
        chk("oor_carry", 32'(ib.carry_out), 32'h0);
        ib.rd_sel_a = 2'd1; ib.rd_sel_b = 2'd2;
        #1;
        chk("oor_reg1", 32'(ib.rd_data_a), 32'h2);
        chk("oor_reg2", 32'(ib.rd_data_b), 32'h3);

        // Synchronous clear zeroes registers, carry and counter
        ia.sclr = 1'b1;
        tick();
        ia.sclr = 1'b0;
        ia.rd_sel_a = 2'd1; ia.rd_sel_b = 2'd3;
        #1;
        chk("sclr_cnt",   32'(ia.cycle_count), 32'h0);
        chk("sclr_carry", 32'(ia.carry_out),   32'h0);
        chk("sclr_reg1",  32'(ia.rd_data_a),   32'h0);
        chk("sclr_reg3",  32'(ia.rd_data_b),   32'h0);

        // Counter wrap: 15 edges reach F, 16th wraps with a one-cycle pulse
        repeat (15) tick();
        chk("cnt_15",      32'(ia.cycle_count), 32'hF);
        chk("cnt_15_wrap", 32'(ia.cycle_wrap),  32'h0);
        tick();
        chk("cnt_wrap0",  32'(ia.cycle_count), 32'h0);
        chk("wrap_pulse", 32'(ia.cycle_wrap),  32'h1);
        tick();
        chk("cnt_wrap1",  32'(ia.cycle_count), 32'h1);
        chk("wrap_clear", 32'(ia.cycle_wrap),  32'h0);

        // sclr overrides a concurrent write
        ia.wr_en = 1'b1; ia.wr_sel = 2'd1; ia.wr_data = 4'hB;
        tick();
        chk("pre_sclr_reg1", 32'(ia.rd_data_a), 32'hB);
        ia.wr_sel = 2'd3; ia.wr_data = 4'hC; ia.sclr = 1'b1;
        tick();
        tick();
        ia.sclr = 1'b0; ia.wr_en = 1'b0;
        chk("sclr_wr_reg1", 32'(ia.rd_data_a),   32'h0);
        chk("sclr_wr_reg3", 32'(ia.rd_data_b),   32'h0);
        chk("sclr_hold_cnt", 32'(ia.cycle_count), 32'h0);

        // Asynchronous reset mid-operation, checked before any further edge
        ia.wr_en = 1'b1; ia.wr_sel = 2'd1; ia.wr_data = 4'h6;
        ia.inc_en = 1'b1; ia.inc_sel = 2'd1;
        tick();
        tick();
        chk("pre_async_cnt", 32'(ia.cycle_count), 32'h2);
        #2;
        clr_n = 1'b0;
        #1;
        chk("async_reg1", 32'(ia.rd_data_a),   32'h0);
        chk("async_cnt",  32'(ia.cycle_count), 32'h0);
        chk("async_carry", 32'(ia.carry_out),  32'h0);
        ia.wr_en = 1'b0; ia.inc_en = 1'b0;
        tick();
        clr_n = 1'b1;
        tick();
        chk("post_async_cnt", 32'(ia.cycle_count), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
